// File: rtl/nano_spi_pkg.sv
// ============================================================================
// Module : nano_spi_pkg
// Brief  : Shared command encodings, frame geometry, FSM states and the
//          frame-assembly helper for the spi_master4nano SPI master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nano_spi_pkg;

    localparam logic [1:0] CMD_WR_CODE = 2'b00;
    localparam logic [1:0] CMD_RD_CODE = 2'b01;
    localparam logic [1:0] CMD_WR_DATA = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_LEN_CODE = 24;
    localparam int FRAME_LEN_DATA = 32;
    localparam int CODE_ADDR_W    = 12;
    localparam int DATA_ADDR_W    = 11;
    localparam int DATA_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Left-aligned frame image: the MSB is the first bit on MOSI. Read
    // commands carry zeros in the data phase; 24-bit frames are padded low.
    function automatic logic [31:0] build_frame(
        input logic [1:0]             cmd,
        input logic [CODE_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]      wdata
    );
        logic [CODE_ADDR_W-1:0] a;
        logic [DATA_W-1:0]      d;
        logic                   is_code;
        is_code = (cmd == CMD_WR_CODE) || (cmd == CMD_RD_CODE);
        a = is_code ? addr : {1'b0, addr[DATA_ADDR_W-1:0]};
        d = ((cmd == CMD_RD_CODE) || (cmd == CMD_RD_DATA)) ? '0 : wdata;
        if (is_code)
            build_frame = {cmd, 2'b00, a[11:8], a[7:0], d[7:0], 8'h00};
        else
            build_frame = {cmd, 2'b00, a[11:8], a[7:0], d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master4nano_if.sv
// ============================================================================
// Module : spi_master4nano_if
// Brief  : Host-side request/response bus of the spi_master4nano SPI master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master4nano_if;
    import nano_spi_pkg::*;

    logic                   START;
    logic [1:0]             CMD;
    logic [CODE_ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0]      WDATA;
    logic                   BUSY;
    logic                   DONE;
    logic                   ERR;
    logic [DATA_W-1:0]      RDATA;

    modport master (
        output START, CMD, ADDR, WDATA,
        input  BUSY, DONE, ERR, RDATA
    );

    modport slave (
        input  START, CMD, ADDR, WDATA,
        output BUSY, DONE, ERR, RDATA
    );
endinterface

`default_nettype wire

// File: rtl/spi_master4nano_sck_divider.sv
// ============================================================================
// Module : sck_divider
// Brief  : Half-period timer producing SCK rise/fall enables every CLK_DIV
//          cycles while i_run is high; restarts in phase 0 when idle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sck_divider #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    output logic      o_rise,
    output logic      o_fall
);
    localparam int                c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;
    logic            r_phase;
    logic            w_tick;

    assign w_tick = i_run && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_run) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + c_ONE;
        end
    end

    // Phase 0 is the SCK-low half, so its end is a rising edge.
    assign o_rise = w_tick & ~r_phase;
    assign o_fall = w_tick &  r_phase;
endmodule

`default_nettype wire

// File: rtl/spi_master4nano.sv
// ============================================================================
// Module : spi_master4nano
// Brief  : Mode-0 SPI master issuing 24/32-bit code/data frames. Read-back of
//          MISO is enabled by defining SPI_READBACK_EN; otherwise reads are
//          rejected with ERR.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master4nano
    import nano_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    spi_master4nano_if.slave bus,
    output logic             SPI_CS,
    output logic             SPI_SCK,
    output logic             SPI_MOSI,
    input  wire logic        SPI_MISO
);
    localparam logic [4:0] c_LAST_DATA = 5'(FRAME_LEN_DATA - 1);
    localparam logic [4:0] c_LAST_CODE = 5'(FRAME_LEN_CODE - 1);

    state_e      r_state, w_state_nxt;
    logic [31:0] r_tx, w_tx_nxt;
    logic [4:0]  r_bit, w_bit_nxt;
    logic        r_is_data, w_is_data_nxt;
    logic        r_cs, w_cs_nxt;
    logic        r_sck, w_sck_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic        w_run, w_rise, w_fall, w_last_bit, w_rd_reject;

    assign w_run = (r_state != ST_IDLE);

    sck_divider #(.CLK_DIV(CLK_DIV)) u_sck_divider (
        .clk    (CLK),
        .rst    (RST),
        .i_run  (w_run),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_last_bit = r_is_data ? (r_bit == c_LAST_DATA) : (r_bit == c_LAST_CODE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_bit     <= '0;
            r_is_data <= 1'b0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_bit     <= w_bit_nxt;
            r_is_data <= w_is_data_nxt;
            r_cs      <= w_cs_nxt;
            r_sck     <= w_sck_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_bit_nxt     = r_bit;
        w_is_data_nxt = r_is_data;
        w_sck_nxt     = r_sck;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sck_nxt = 1'b0;
                if (bus.START) begin
                    if (w_rd_reject) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_SETUP;
                        w_tx_nxt      = build_frame(bus.CMD, bus.ADDR, bus.WDATA);
                        w_bit_nxt     = '0;
                        w_is_data_nxt = (bus.CMD == CMD_WR_DATA) || (bus.CMD == CMD_RD_DATA);
                    end
                end
            end
            ST_SETUP: begin
                if (w_fall) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_rise) w_sck_nxt = 1'b1;
                // MOSI only advances on the falling edge, keeping it stable while SCK is high.
                if (w_fall) begin
                    w_sck_nxt = 1'b0;
                    w_tx_nxt  = {r_tx[30:0], 1'b0};
                    if (w_last_bit) w_state_nxt = ST_HOLD;
                    else            w_bit_nxt   = r_bit + 5'd1;
                end
            end
            ST_HOLD: begin
                if (w_fall) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sck_nxt   = 1'b0;
            end
        endcase
        w_cs_nxt   = !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT) ||
                       (w_state_nxt == ST_HOLD));
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign SPI_CS   = r_cs;
    assign SPI_SCK  = r_sck;
    assign SPI_MOSI = r_tx[31];
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;
    assign bus.ERR  = r_err;

`ifdef SPI_READBACK_EN
    logic                r_is_read;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rdata;

    assign w_rd_reject = 1'b0;

    // Only data-phase bits (index 16 and up) are captured; clearing at start
    // leaves code reads zero-extended.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_is_read <= 1'b0;
            r_rx      <= '0;
            r_rdata   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.START) begin
                r_is_read <= (bus.CMD == CMD_RD_CODE) || (bus.CMD == CMD_RD_DATA);
                r_rx      <= '0;
            end else if ((r_state == ST_SHIFT) && w_rise && r_bit[4]) begin
                r_rx      <= {r_rx[DATA_W-2:0], SPI_MISO};
            end
            if ((r_state == ST_GAP) && w_fall && r_is_read)
                r_rdata <= r_rx;
        end
    end

    assign bus.RDATA = r_rdata;
`else
    logic w_unused_miso;

    assign w_unused_miso = SPI_MISO;
    assign w_rd_reject   = bus.CMD[0];
    assign bus.RDATA     = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_spi_master4nano.sv
// ============================================================================
// Module : tb_spi_master4nano
// Brief  : Directed self-checking bench with a mode-0 slave model and a frame
//          scoreboard for spi_master4nano.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master4nano;
    typedef struct {
        int          len;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs, spi_sck, spi_mosi, spi_miso;

    spi_master4nano_if bus ();

    spi_master4nano dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bus),
        .SPI_CS   (spi_cs),
        .SPI_SCK  (spi_sck),
        .SPI_MOSI (spi_mosi),
        .SPI_MISO (spi_miso)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    bit          mon_en   = 1'b0;
    logic [31:0] cap      = '0;
    int          nbits    = 0;
    int          miso_idx = 0;
    int          cs_falls = 0;
    int          frames   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic [31:0] slave_word = '0;
    int          slave_len  = 0;
    logic        prev_sck  = 1'b0;
    logic        prev_mosi = 1'b0;
    logic [15:0] last_rd   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: captures MOSI on SCK rise, shifts MISO out after each fall.
    assign spi_miso = (miso_idx < slave_len) ? slave_word[slave_len - 1 - miso_idx] : 1'b0;

    always @(negedge spi_cs) begin
        cap = '0; nbits = 0; miso_idx = 0; cs_falls++;
    end
    always @(posedge spi_sck) if (!spi_cs) begin
        cap = {cap[30:0], spi_mosi}; nbits++;
    end
    always @(negedge spi_sck) if (!spi_cs) miso_idx++;

    always @(posedge spi_cs) if (mon_en) begin
        exp_t e;
        frames++;
        if (sb.size() == 0) begin
            chk("unexpected_frame", 32'(nbits), 32'd0);
        end else begin
            e = sb.pop_front();
            chk("frame_len", 32'(nbits), 32'(e.len));
            chk("frame_bits", cap, e.val);
        end
    end

    always @(posedge clk) begin
        if (bus.DONE === 1'b1) done_cnt++;
        if (bus.ERR === 1'b1)  err_cnt++;
    end

    always @(negedge clk) if (mon_en) begin
        if (spi_cs === 1'b1) chk("sck_low_when_cs_high", {31'd0, spi_sck}, 32'd0);
        if (spi_sck === 1'b1 && prev_sck === 1'b1)
            chk("mosi_stable_sck_high", {31'd0, spi_mosi}, {31'd0, prev_mosi});
        prev_sck  = spi_sck;
        prev_mosi = spi_mosi;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_start(input logic [1:0] cmd, input logic [11:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        bus.START = 1'b1; bus.CMD = cmd; bus.ADDR = addr; bus.WDATA = wdata;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 4000) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] cmd, input logic [11:0] addr,
                           input logic [15:0] wdata, input int exp_len, input logic [31:0] exp_val,
                           input int exp_cyc, input logic [15:0] exp_rd);
        int cyc;
        sb.push_back('{exp_len, exp_val});
        drive_start(cmd, addr, wdata);
        chk({tag, "_busy_setup"}, {31'd0, bus.BUSY}, 32'd1);
        chk({tag, "_cs_setup"}, {31'd0, spi_cs}, 32'd0);
        wait_done(tag, cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_busy_at_done"}, {31'd0, bus.BUSY}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, bus.RDATA}, {16'd0, exp_rd});
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, bus.DONE}, 32'd0);
    endtask

    initial begin
        int cyc;
        int d0, f0, e0, c0;
        bus.START = 1'b0; bus.CMD = 2'b00; bus.ADDR = '0; bus.WDATA = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'd0, spi_cs}, 32'd1);
        chk("rst_sck", {31'd0, spi_sck}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_done", {31'd0, bus.DONE}, 32'd0);
        chk("rst_err", {31'd0, bus.ERR}, 32'd0);
        chk("rst_rdata", {16'd0, bus.RDATA}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Code and data writes
        run_txn("wr_code_05A", 2'b00, 12'h05A, 16'h00C3, 24, 32'h005AC3, 216, last_rd);
        run_txn("wr_data_FFF", 2'b10, 12'hFFF, 16'hBEEF, 32, 32'h87FFBEEF, 280, last_rd);
        run_txn("wr_code_ABC", 2'b00, 12'hABC, 16'h01FF, 24, 32'h0ABCFF, 216, last_rd);
        run_txn("wr_data_800", 2'b10, 12'h800, 16'h0001, 32, 32'h80000001, 280, last_rd);

        // Reads
`ifdef SPI_READBACK_EN
        slave_word = 32'hFFFF1234; slave_len = 32;
        last_rd = 16'h1234;
        run_txn("rd_data_123", 2'b11, 12'h123, 16'hAAAA, 32, 32'hC1230000, 280, last_rd);
        slave_word = 32'h00FFFFA5; slave_len = 24;
        last_rd = 16'h00A5;
        run_txn("rd_code_0F0", 2'b01, 12'h0F0, 16'h5555, 24, 32'h40F000, 216, last_rd);
        run_txn("wr_after_rd", 2'b00, 12'h001, 16'h0080, 24, 32'h000180, 216, last_rd);
        slave_len = 0;
`else
        c0 = cs_falls; e0 = err_cnt;
        drive_start(2'b11, 12'h123, 16'hAAAA);
        chk("rd_rej_err_pulse", {31'd0, bus.ERR}, 32'd1);
        chk("rd_rej_busy", {31'd0, bus.BUSY}, 32'd0);
        @(negedge clk);
        chk("rd_rej_err_clear", {31'd0, bus.ERR}, 32'd0);
        drive_start(2'b01, 12'h0F0, 16'h0000);
        repeat (40) @(negedge clk);
        chk("rd_rej_no_cs", 32'(cs_falls), 32'(c0));
        chk("rd_rej_err_count", 32'(err_cnt), 32'(e0 + 2));
        chk("rd_rej_rdata", {16'd0, bus.RDATA}, 32'd0);
`endif

        // START during SHIFT is ignored
        d0 = done_cnt; f0 = frames;
        sb.push_back('{32, 32'h83455555});
        drive_start(2'b10, 12'h345, 16'h5555);
        cyc = 0;
        while (nbits < 5 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("ign_reached_shift", {31'd0, (nbits >= 5)}, 32'd1);
        drive_start(2'b00, 12'h111, 16'h0022);
        wait_done("ign", cyc);
        repeat (80) @(negedge clk);
        chk("ign_one_done", 32'(done_cnt), 32'(d0 + 1));
        chk("ign_one_frame", 32'(frames), 32'(f0 + 1));
        chk("ign_idle_after", {31'd0, bus.BUSY}, 32'd0);

        // START held high restarts the cycle after DONE
        d0 = done_cnt;
        sb.push_back('{24, 32'h005AC3});
        sb.push_back('{24, 32'h005AC3});
        @(negedge clk);
        bus.START = 1'b1; bus.CMD = 2'b00; bus.ADDR = 12'h05A; bus.WDATA = 16'h00C3;
        @(negedge clk);
        wait_done("held1", cyc);
        @(negedge clk);
        chk("held_restart_busy", {31'd0, bus.BUSY}, 32'd1);
        bus.START = 1'b0;
        wait_done("held2", cyc);
        repeat (3) @(negedge clk);
        chk("held_two_done", 32'(done_cnt), 32'(d0 + 2));

        // Reset at bit 10 aborts the frame
        d0 = done_cnt;
        sb.push_back('{10, 32'h200});
        drive_start(2'b10, 12'h800, 16'h0001);
        cyc = 0;
        while (nbits != 10 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("abort_reached_bit10", 32'(nbits), 32'd10);
        rst = 1'b1;
        #1;
        chk("abort_cs", {31'd0, spi_cs}, 32'd1);
        chk("abort_sck", {31'd0, spi_sck}, 32'd0);
        chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        run_txn("post_abort", 2'b10, 12'hFFF, 16'hBEEF, 32, 32'h87FFBEEF, 280, last_rd);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/spi_master4nano.md
SPI_MASTER4NANO -- requirements
Module: spi_master4nano

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in CLK cycles; SCK = CLK/(2*CLK_DIV), which is 195.3125 kHz at 1.5625 MHz.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port START, input, 1 bit: transaction request, sampled when not busy.
REQ-005 SHALL have port CMD, input, 2 bits: 00 write code byte, 01 read code byte, 10 write data word, 11 read data word.
REQ-006 SHALL have port ADDR, input, 12 bits: code address (12 b) or data address (low 11 b).
REQ-007 SHALL have port WDATA, input, 16 bits: write payload; code writes use [7:0].
REQ-008 SHALL have port BUSY, output, 1 bit: transaction in progress.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port ERR, output, 1 bit: one-cycle rejected-command pulse.
REQ-011 SHALL have port RDATA, output, 16 bits: read result, zero-extended for code reads.
REQ-012 SHALL have SPI ports SPI_CS (output, 1, active-low), SPI_SCK (output, 1), SPI_MOSI (output, 1) and SPI_MISO (input, 1).

Function
REQ-013 SPI mode 0, MSB first: MOSI SHALL change only while SCK is low; MISO SHALL be sampled on the SCK rising edge.
REQ-014 Frame byte0 SHALL be {CMD, 2'b00, A[11:8]} and byte1 SHALL be A[7:0], where A = ADDR for code commands and A = {1'b0, ADDR[10:0]} for data commands.
REQ-015 The data phase SHALL be 8 bits for code commands and 16 bits for data commands, giving 24- or 32-bit frames.
REQ-016 Write commands SHALL shift WDATA during the data phase; read commands SHALL drive MOSI=0 and shift MISO into a shift register during the data phase.
REQ-017 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-018 IDLE→SETUP SHALL occur on START=1: CMD, ADDR and WDATA latched, BUSY=1 in the next cycle, CS low.
REQ-019 SETUP SHALL last 2*CLK_DIV cycles with SCK low and MOSI = first bit.
REQ-020 SHIFT SHALL produce N full SCK periods (N = 24 or 32), each low half then high half of CLK_DIV cycles.
REQ-021 HOLD SHALL last 2*CLK_DIV cycles with CS low and SCK low.
REQ-022 GAP SHALL last 2*CLK_DIV cycles with CS high, then return to IDLE.
REQ-023 On the GAP→IDLE cycle: DONE=1 and BUSY=0; for reads, RDATA SHALL update in the same cycle, otherwise RDATA holds its previous value.
REQ-024 START while BUSY=1 SHALL be ignored and not queued; START held high in IDLE SHALL begin a new transaction the cycle after DONE.
REQ-025 SCK SHALL never glitch; CS SHALL be high and SCK low whenever in IDLE.

Reset
REQ-026 RST SHALL force immediately (asynchronously) IDLE, SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, BUSY=0, DONE=0, ERR=0 and RDATA=0.
REQ-027 Reset mid-frame SHALL abort the frame with no DONE pulse; the first START after RST deasserts SHALL begin a clean frame.

Configuration
REQ-028 With macro SPI_READBACK_EN defined: read commands (CMD[0]=1) SHALL execute per REQ-016 and REQ-023.
REQ-029 Without SPI_READBACK_EN: read commands SHALL produce no frame (CS stays high) and pulse ERR=1 for one cycle after START, with BUSY staying 0; RDATA SHALL be constant 0 and the MISO shift register omitted.

Structure
REQ-030 Package nano_spi_pkg SHALL hold the CMD encodings, the frame lengths (24/32), the address widths (12/11) and the FSM state enumeration.
REQ-031 One sub-module, sck_divider, SHALL generate the SCK-edge enables from CLK_DIV; the FSM, shifter and bit counter stay in spi_master4nano.

Verification
REQ-032 CMD=00, ADDR=0x05A, WDATA=0x00C3 SHALL give MOSI 0x00,0x5A,0xC3 over 24 SCK rising edges, then DONE after 24*8+24 cycles from the SETUP start.
REQ-033 CMD=10, ADDR=0xFFF, WDATA=0xBEEF SHALL give byte0=0x87, byte1=0xFF and data 0xBEEF (address bit 11 forced 0).
REQ-034 CMD=11 with the model slave returning 0x1234 SHALL give RDATA=0x1234 on the DONE cycle (with SPI_READBACK_EN); without the macro, ERR pulses once, no CS activity occurs and RDATA=0.
REQ-035 A START pulse during SHIFT SHALL be ignored: exactly one frame occurs and one DONE pulse.
REQ-036 RST asserted at bit 10 of a frame SHALL give CS=1, SCK=0, BUSY=0 at once with no DONE; the next START SHALL produce a full correct frame.
REQ-037 Checker: SCK SHALL be low whenever CS is high, and MOSI SHALL be stable during every SCK-high half.
